// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared types for the memory-port arbiter           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // A single-beat line still needs one counter bit.
  function automatic int beat_cnt_width(input int beats);
    return (beats == 1) ? 1 : $clog2(beats);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_beat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_beat_counter : per-line beat counter with last-beat flag |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arb_beat_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_BEATS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int              CNT_W  = beat_cnt_width(MEM_BEATS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MEM_BEATS - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_inc;

  generate
    if (MEM_BEATS == 1) begin : g_single
      assign w_count_inc = '0;
    end else begin : g_multi
      // Power-of-two line length lets the counter wrap on its own.
      assign w_count_inc = r_count + CNT_W'(1);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_count_inc;
    end
  end

  assign last = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : I-cache / D-cache arbiter for one main-memory port |
// | Build option: MEM_ARB_RR_EN selects round-robin tie-breaking     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MEM_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic              ic_resp_last,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic              dc_resp_last,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              owner,
  output logic              err
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_owner;
  logic       w_owner_next;
  logic       r_err;
  logic       w_grant;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_cnt_last;

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the port to whoever did not hold it last.
  assign w_grant = (ic_req_valid && dc_req_valid) ? ~r_owner
                 : (dc_req_valid ? OWNER_D : OWNER_I);
`else
  assign w_grant = dc_req_valid ? OWNER_D : OWNER_I;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= OWNER_I;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      if (mem_resp_valid && (r_state != RDATA)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = (r_owner == OWNER_D) ? dc_req_addr : ic_req_addr;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    ic_resp_valid   = 1'b0;
    ic_resp_last    = 1'b0;
    dc_resp_valid   = 1'b0;
    dc_resp_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          w_state_next = CMD;
          w_owner_next = w_grant;
        end
      end
      CMD: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = (r_owner == OWNER_D) && dc_req_rw;
        ic_req_ready  = (r_owner == OWNER_I) && mem_req_ready;
        dc_req_ready  = (r_owner == OWNER_D) && mem_req_ready;
        if (mem_req_ready) begin
          w_cnt_clr    = 1'b1;
          w_state_next = mem_req_rw ? WDATA : RDATA;
        end
      end
      WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        if (dc_wdata_valid && mem_wdata_ready) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            w_state_next = IDLE;
          end
        end
      end
      RDATA: begin
        if (r_owner == OWNER_D) begin
          dc_resp_valid = mem_resp_valid;
          dc_resp_last  = mem_resp_valid && w_cnt_last;
        end else begin
          ic_resp_valid = mem_resp_valid;
          ic_resp_last  = mem_resp_valid && w_cnt_last;
        end
        if (mem_resp_valid) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  mem_arb_beat_counter #(
    .MEM_BEATS(MEM_BEATS)
  ) u_beat_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (w_cnt_clr),
    .inc  (w_cnt_inc),
    .last (w_cnt_last)
  );

  assign mem_wdata    = dc_wdata;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;
  assign busy         = (r_state != IDLE);
  assign owner        = r_owner;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 128;
  localparam int MEM_BEATS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ic_req_valid, ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid, ic_resp_last;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_resp_valid, dc_resp_last;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy, owner, err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_data_q[$];
  logic              exp_last_q[$];

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BEATS(MEM_BEATS)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_last(ic_resp_last), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
    .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_last(dc_resp_last),
    .dc_resp_data(dc_resp_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
    dc_wdata_valid = 0; dc_wdata = '0;
    mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  // Runs one read line for the expected owner; memory beats are base+0..base+3.
  task automatic read_line(input logic exp_side, input logic [ADDR_W-1:0] exp_addr,
                           input logic [DATA_W-1:0] base, input bit drop, output int lat);
    logic [DATA_W-1:0] ed, got_d;
    logic el, got_v, got_l, oth_v;
    lat = 0;
    do begin
      @(negedge clk); #1; lat++;
    end while (!mem_req_valid && lat < 8);
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_cmd_timeout: mem_req_valid=%b after %0d cycles, expected 1", mem_req_valid, lat);
      return;
    end
    checks++;
    if (owner !== exp_side) begin
      errors++; $display("FAIL rd_owner: got %b expected %b", owner, exp_side);
    end
    checks++;
    if (mem_req_addr !== exp_addr) begin
      errors++; $display("FAIL rd_addr: got %h expected %h", mem_req_addr, exp_addr);
    end
    checks++;
    if ({mem_req_rw, ic_req_ready, dc_req_ready} !== {1'b0, ~exp_side, exp_side}) begin
      errors++;
      $display("FAIL rd_cmd_hs: rw/ic_rdy/dc_rdy got %b%b%b expected 0%b%b",
               mem_req_rw, ic_req_ready, dc_req_ready, ~exp_side, exp_side);
    end
    for (int i = 0; i < MEM_BEATS; i++) begin
      @(negedge clk);
      if (drop && i == 0) begin
        ic_req_valid = 0;
        dc_req_valid = 0;
      end
      mem_resp_valid = 1;
      mem_resp_data  = base + DATA_W'(i);
      exp_data_q.push_back(base + DATA_W'(i));
      exp_last_q.push_back(i == MEM_BEATS - 1);
      #1;
      ed    = exp_data_q.pop_front();
      el    = exp_last_q.pop_front();
      got_v = (exp_side == OWNER_D) ? dc_resp_valid : ic_resp_valid;
      got_d = (exp_side == OWNER_D) ? dc_resp_data  : ic_resp_data;
      got_l = (exp_side == OWNER_D) ? dc_resp_last  : ic_resp_last;
      oth_v = (exp_side == OWNER_D) ? ic_resp_valid : dc_resp_valid;
      checks++;
      if ({got_v, oth_v} !== 2'b10) begin
        errors++;
        $display("FAIL rd_beat%0d_valid: owner/other valid got %b%b expected 10", i, got_v, oth_v);
      end
      checks++;
      if (got_d !== ed || got_l !== el) begin
        errors++;
        $display("FAIL rd_beat%0d_data: got %h last %b expected %h last %b", i, got_d, got_l, ed, el);
      end
    end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rd_end_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    @(negedge clk); #1;
    checks++;
    if ({busy, owner, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status: busy/owner/err got %b%b%b expected 000", busy, owner, err);
    end
    checks++;
    if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_wdata_valid, dc_wdata_ready,
         ic_resp_valid, ic_resp_last, dc_resp_valid, dc_resp_last} !== 9'b0) begin
      errors++; $display("FAIL reset_handshakes: some handshake output high, expected all 0");
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_ic_read();
    int lat;
    @(negedge clk);
    ic_req_valid = 1; ic_req_addr = 32'h100; mem_req_ready = 1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL ic_cmd_early: mem_req_valid got %b expected 0", mem_req_valid);
    end
    read_line(OWNER_I, 32'h100, 128'hA0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL ic_latency: got %0d cycles expected 1", lat);
    end
  endtask

  task automatic test_dc_write();
    logic [DATA_W-1:0] wd[MEM_BEATS];
    logic [DATA_W-1:0] ed;
    int k, cyc;
    for (int i = 0; i < MEM_BEATS; i++) begin
      wd[i] = 128'hD0 + DATA_W'(i);
      exp_data_q.push_back(wd[i]);
    end
    @(negedge clk);
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h200; mem_req_ready = 1;
    @(negedge clk); #1;
    checks++;
    if ({mem_req_valid, mem_req_rw, dc_req_ready, ic_req_ready, owner} !== 5'b11101) begin
      errors++;
      $display("FAIL wr_cmd: valid/rw/dc_rdy/ic_rdy/owner got %b%b%b%b%b expected 11101",
               mem_req_valid, mem_req_rw, dc_req_ready, ic_req_ready, owner);
    end
    checks++;
    if (mem_req_addr !== 32'h200) begin
      errors++; $display("FAIL wr_addr: got %h expected 00000200", mem_req_addr);
    end
    k = 0; cyc = 0;
    while (k < MEM_BEATS && cyc < 40) begin
      @(negedge clk);
      dc_req_valid    = 0;
      dc_wdata_valid  = 1;
      dc_wdata        = wd[k];
      mem_wdata_ready = (cyc % 2 == 1);
      cyc++;
      #1;
      checks++;
      if (mem_wdata_valid !== 1'b1 || dc_wdata_ready !== mem_wdata_ready) begin
        errors++;
        $display("FAIL wr_steer: mem_wdata_valid %b dc_wdata_ready %b expected 1 and %b",
                 mem_wdata_valid, dc_wdata_ready, mem_wdata_ready);
      end
      if (mem_wdata_valid && mem_wdata_ready) begin
        ed = exp_data_q.pop_front();
        checks++;
        if (mem_wdata !== ed) begin
          errors++; $display("FAIL wr_beat%0d: got %h expected %h", k, mem_wdata, ed);
        end
        k++;
      end
    end
    @(negedge clk);
    dc_wdata_valid = 0; mem_wdata_ready = 1;
    #1;
    checks++;
    if (k !== MEM_BEATS) begin
      errors++; $display("FAIL wr_count: got %0d handshakes expected %0d", k, MEM_BEATS);
    end
    checks++;
    if ({busy, mem_wdata_valid} !== 2'b00) begin
      errors++; $display("FAIL wr_end: busy/mem_wdata_valid got %b%b expected 00", busy, mem_wdata_valid);
    end
  endtask

  task automatic test_arbitration();
    int lat;
    logic exp_side;
    apply_reset();
    @(negedge clk);
    ic_req_valid = 1; ic_req_addr = 32'h300;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h400;
    mem_req_ready = 1;
    for (int w = 0; w < 4; w++) begin
`ifdef MEM_ARB_RR_EN
      exp_side = (w % 2 == 0) ? OWNER_D : OWNER_I;
`else
      exp_side = OWNER_D;
`endif
      read_line(exp_side, (exp_side == OWNER_D) ? 32'h400 : 32'h300,
                128'hC0 + DATA_W'(w * 16), (w == 3), lat);
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL arb_w%0d_latency: got %0d cycles expected 1", w, lat);
      end
    end
  endtask

  task automatic test_stray();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL stray_pre_err: got %b expected 0", err);
    end
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_data = 128'hEE;
    #1;
    checks++;
    if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
      errors++; $display("FAIL stray_resp: ic/dc resp_valid got %b%b expected 00", ic_resp_valid, dc_resp_valid);
    end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    checks++;
    if ({err, busy} !== 2'b10) begin
      errors++; $display("FAIL stray_err: err/busy got %b%b expected 10", err, busy);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL stray_sticky: err got %b expected 1", err);
    end
  endtask

  task automatic test_reset_mid_rdata();
    int lat;
    @(negedge clk);
    ic_req_valid = 1; ic_req_addr = 32'h500; mem_req_ready = 1;
    @(negedge clk); #1;
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL mid_cmd: mem_req_valid got %b expected 1", mem_req_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ic_req_valid = 0;
      mem_resp_valid = 1; mem_resp_data = 128'hF0 + DATA_W'(i);
      #1;
      checks++;
      if (ic_resp_valid !== 1'b1 || ic_resp_data !== 128'hF0 + DATA_W'(i)) begin
        errors++; $display("FAIL mid_beat%0d: valid %b data %h expected 1 and %h",
                           i, ic_resp_valid, ic_resp_data, 128'hF0 + DATA_W'(i));
      end
    end
    @(negedge clk);
    mem_resp_valid = 0;
    reset = 0;
    #1;
    checks++;
    if ({busy, err, owner} !== 3'b000 || dut.r_state !== IDLE) begin
      errors++; $display("FAIL mid_reset_state: busy/err/owner got %b%b%b state %0d expected 000 state 0",
                         busy, err, owner, dut.r_state);
    end
    checks++;
    if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_wdata_valid, dc_wdata_ready,
         ic_resp_valid, dc_resp_valid} !== 7'b0) begin
      errors++; $display("FAIL mid_reset_handshakes: some handshake output high, expected all 0");
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    ic_req_valid = 1; ic_req_addr = 32'h600;
    read_line(OWNER_I, 32'h600, 128'hB0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL mid_recover_latency: got %0d cycles expected 1", lat);
    end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_arbitration();
    test_stray();
    test_reset_mid_rdata();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
